max_tree_pipe: RTL

//  Parametrised pipelined max/min reduction over N lanes of W bits; returns the extreme value and its lane index.

---
 rtl/max_tree_pipe.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/max_tree_pipe.sv
// max_tree_pipe
//   Pipelined max/min reduction over N lanes of W bits. Returns the extreme
//   value and the lane index it came from. Each sample carries its own
//   max/min select. A single global advance signal stalls the whole pipe
//   under downstream back-pressure.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous reset, active-high
//   valid_in   sample present on data_in / mode_min
//   in_ready   sample is taken this cycle when valid_in is also high
//   data_in    N*W bits, lane i = data_in[i*W +: W]
//   mode_min   0: select maximum, 1: select minimum
//   valid_out  result / index hold a valid sample
//   out_ready  downstream consumes the result this cycle
//   result     extreme value (registered)
//   index      lane number of result (registered)
module max_tree_pipe #(
  parameter int N      = 8,
  parameter int W      = 8,
  parameter int SIGNED = 1,
  parameter int IDX_W  = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               valid_in,
  output logic               in_ready,
  input  logic [N*W-1:0]     data_in,
  input  logic               mode_min,
  output logic               valid_out,
  input  logic               out_ready,
  output logic [W-1:0]       result,
  output logic [IDX_W-1:0]   index
);

  localparam int L = $clog2(N);
  localparam int H = N / 2;

  // Flipping the MSB maps two's-complement order onto unsigned order, so a
  // single unsigned comparator serves both modes.
  localparam logic [W-1:0] BIAS = (SIGNED != 0) ? (W'(1) << (W - 1)) : '0;

  // Stage k (1..L) holds N/2^k live entries; higher slots stay at zero.
  logic [W-1:0]     val_q [1:L][H];
  logic [IDX_W-1:0] idx_q [1:L][H];
  logic             vld_q [1:L];
  logic             mode_q [1:L];

  // Inputs seen by each stage: lanes for stage 1, previous stage otherwise.
  logic [W-1:0]     src_val  [1:L][N];
  logic [IDX_W-1:0] src_idx  [1:L][N];
  logic             src_vld  [1:L];
  logic             src_mode [1:L];

  logic [W-1:0]     nxt_val [1:L][H];
  logic [IDX_W-1:0] nxt_idx [1:L][H];

  logic adv;

  assign adv       = out_ready | ~valid_out;
  assign in_ready  = adv;
  assign valid_out = vld_q[L];
  assign result    = val_q[L][0];
  assign index     = idx_q[L][0];

  // Right operand wins only on strict improvement, so ties keep the lower lane.
  function automatic logic right_wins(input logic [W-1:0] lv,
                                      input logic [W-1:0] rv,
                                      input logic         mn);
    logic [W-1:0] lk;
    logic [W-1:0] rk;
    lk = lv ^ BIAS;
    rk = rv ^ BIAS;
    return mn ? (rk < lk) : (rk > lk);
  endfunction

  always_comb begin
    for (int unsigned k = 1; k <= L; k++) begin
      src_vld[k]  = 1'b0;
      src_mode[k] = 1'b0;
      for (int unsigned i = 0; i < N; i++) begin
        src_val[k][i] = '0;
        src_idx[k][i] = '0;
      end
    end

    src_vld[1]  = valid_in;
    src_mode[1] = mode_min;
    for (int unsigned i = 0; i < N; i++) begin
      src_val[1][i] = data_in[i*W +: W];
      src_idx[1][i] = IDX_W'(i);
    end

    for (int unsigned k = 2; k <= L; k++) begin
      src_vld[k]  = vld_q[k-1];
      src_mode[k] = mode_q[k-1];
      for (int unsigned j = 0; j < H; j++) begin
        src_val[k][j] = val_q[k-1][j];
        src_idx[k][j] = idx_q[k-1][j];
      end
    end

    for (int unsigned k = 1; k <= L; k++) begin
      for (int unsigned j = 0; j < H; j++) begin
        nxt_val[k][j] = '0;
        nxt_idx[k][j] = '0;
        if (j < (unsigned'(N) >> k)) begin
          if (right_wins(src_val[k][2*j], src_val[k][2*j+1], src_mode[k])) begin
            nxt_val[k][j] = src_val[k][2*j+1];
            nxt_idx[k][j] = src_idx[k][2*j+1];
          end else begin
            nxt_val[k][j] = src_val[k][2*j];
            nxt_idx[k][j] = src_idx[k][2*j];
          end
        end
      end
    end
  end

  // Global stall: every stage loads together (bubbles included) or holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 1; k <= L; k++) begin
        vld_q[k]  <= 1'b0;
        mode_q[k] <= 1'b0;
        for (int unsigned j = 0; j < H; j++) begin
          val_q[k][j] <= '0;
          idx_q[k][j] <= '0;
        end
      end
    end else if (adv) begin
      for (int unsigned k = 1; k <= L; k++) begin
        vld_q[k]  <= src_vld[k];
        mode_q[k] <= src_mode[k];
        for (int unsigned j = 0; j < H; j++) begin
          val_q[k][j] <= nxt_val[k][j];
          idx_q[k][j] <= nxt_idx[k][j];
        end
      end
    end
  end

endmodule
